// File: rtl/uart_rx_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_sink                                                  |
// | Description : 8N1 UART receiver (LSB first) with a one-byte holding         |
// |               register on a valid/ready interface. Reports framing          |
// |               errors and overruns as single-cycle pulses.                   |
// | Ports       : clk       - single clock                                      |
// |               rst       - synchronous active-high reset                     |
// |               rxd       - asynchronous serial input, idle high              |
// |               data      - received byte, stable while valid is high         |
// |               valid     - holding register contains a byte                  |
// |               ready     - consumer accepts (transfer on valid && ready)     |
// |               busy      - receiver FSM is not idle                          |
// |               frame_err - pulse: stop bit sampled low                       |
// |               overrun   - pulse: complete byte dropped, holding reg full    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module uart_rx_sink #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              c_CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_RELOAD  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_RELOAD = c_CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_frame_err;
  logic               r_overrun;
  logic               w_rxs;
  logic               w_drain;

  assign w_rxs   = r_sync2;
  assign w_drain = r_valid && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1     <= rxd;
      r_sync2     <= r_sync1;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // A drain clears valid; a load later in this block overrides it so a
      // simultaneous load and drain becomes a back-to-back transfer.
      if (w_drain) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_cnt   <= c_HALF_RELOAD;
          end
        end

        S_START: begin
          if (r_cnt == '0) begin
            if (w_rxs) begin
              // Line went back high before mid start bit: treat as glitch.
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_idx   <= 3'd0;
              r_cnt   <= c_BIT_RELOAD;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_DATA: begin
          if (r_cnt == '0) begin
            r_shift[r_idx] <= w_rxs;
            r_cnt          <= c_BIT_RELOAD;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_STOP: begin
          if (r_cnt == '0) begin
            if (w_rxs) begin
              if (!r_valid || ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end

        S_WAIT_IDLE: begin
          // Holding here until the line recovers makes a break report once.
          if (w_rxs) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign busy      = (r_state != S_IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_sink                                               |
// | Description : Self-checking bench for uart_rx_sink. A frame-level model     |
// |               predicts the outcome of each frame at its stop-sample edge    |
// |               and is compared against the DUT every cycle.                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart_rx_sink;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rxd   = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_sink #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Frame outcome scheduled at the edge where its stop bit is sampled.
  typedef struct {
    int         t;
    logic [7:0] b;
    logic       stop;
  } ev_t;
  ev_t evq[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;

  always @(posedge clk) begin
    logic old_v;
    ev_t  e;
    cyc = cyc + 1;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      evq.delete();
    end else begin
      m_fe  = 1'b0;
      m_ov  = 1'b0;
      old_v = m_valid;
      if (old_v && ready) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].t == cyc) begin
        e = evq.pop_front();
        if (!e.stop) m_fe = 1'b1;
        else if (!old_v || ready) begin
          m_data  = e.b;
          m_valid = 1'b1;
        end else m_ov = 1'b1;
      end
    end
  end

  // Observation of the DUT and per-cycle comparison against the model.
  bit         chk_en    = 1'b0;
  logic       prev_v    = 1'b0;
  int         last_vcyc = -1;
  logic [7:0] last_vdata = 8'h00;
  int         fe_cnt    = 0;
  int         ov_cnt    = 0;
  logic [7:0] xlog[$];

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({valid, data, frame_err, overrun} !== {m_valid, m_data, m_fe, m_ov}) begin
        errors++;
        $display("FAIL cycle %0d outputs: got v=%b d=%h fe=%b ov=%b, want v=%b d=%h fe=%b ov=%b",
                 cyc, valid, data, frame_err, overrun, m_valid, m_data, m_fe, m_ov);
      end
      if (valid === 1'b1 && prev_v !== 1'b1) begin
        last_vcyc  = cyc;
        last_vdata = data;
      end
      if (valid === 1'b1 && ready === 1'b1) xlog.push_back(data);
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      prev_v = valid;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  int last_t0 = 0;

  // Drives one full frame; returns one cycle before the stop bit ends so a
  // following call starts with zero idle gap.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    @(posedge clk); #1;
    last_t0 = cyc + 1;
    e.t     = last_t0 + 2 + H + 9 * C;
    e.b     = b;
    e.stop  = stop;
    evq.push_back(e);
    rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(posedge clk); #1;
      rxd = b[i];
    end
    repeat (C) @(posedge clk); #1;
    rxd = stop;
    repeat (C - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n0;
  int fe0;
  int ov0;
  int t0r;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_data", int'(data), 0);
    rst = 1'b0;
    idle(10);

    // Single byte with ready held high.
    ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    idle(5);
    chk("a5_valid_cycle", last_vcyc, last_t0 + 2 + 8 + 144);
    chk("a5_data", int'(last_vdata), 8'hA5);
    chk("a5_xfers", xlog.size(), 1);
    chk("a5_flags", fe_cnt + ov_cnt, 0);

    // Back-to-back frames, zero idle gap.
    n0 = xlog.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(5);
    chk("b2b_count", xlog.size() - n0, 3);
    if (xlog.size() >= n0 + 3) begin
      chk("b2b_byte0", int'(xlog[n0]), 8'h00);
      chk("b2b_byte1", int'(xlog[n0 + 1]), 8'hFF);
      chk("b2b_byte2", int'(xlog[n0 + 2]), 8'h3C);
    end
    chk("b2b_flags", fe_cnt + ov_cnt, 0);

    // Overrun with ready low.
    ready = 1'b0;
    ov0   = ov_cnt;
    n0    = xlog.size();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(5);
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_data", int'(data), 8'h11);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    idle(2);
    chk("ovr_drained_valid", int'(valid), 0);
    chk("ovr_drained_xfers", xlog.size() - n0, 1);
    if (xlog.size() > n0) chk("ovr_drained_byte", int'(xlog[n0]), 8'h11);

    // Drain coinciding with the next load.
    ov0 = ov_cnt;
    n0  = xlog.size();
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        int stop_e;
        @(posedge clk); #1;
        stop_e = cyc + 1 + 2 + H + 9 * C;
        while (cyc != stop_e - 1) begin
          @(posedge clk); #1;
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
      end
    join
    idle(3);
    chk("b2b_load_valid", int'(valid), 1);
    chk("b2b_load_data", int'(data), 8'h22);
    chk("b2b_load_no_ovr", ov_cnt - ov0, 0);
    chk("b2b_load_xfers", xlog.size() - n0, 1);
    if (xlog.size() > n0) chk("b2b_load_byte", int'(xlog[n0]), 8'h11);
    ready = 1'b1;
    idle(3);
    ready = 1'b1;

    // Bad stop bit followed by a long break.
    fe0 = fe_cnt;
    n0  = xlog.size();
    send_frame(8'h55, 1'b0);
    repeat (40 * C) @(posedge clk);
    #1;
    rxd = 1'b1;
    idle(3 * C);
    chk("break_fe_pulses", fe_cnt - fe0, 1);
    chk("break_no_valid", xlog.size() - n0, 0);
    send_frame(8'h7E, 1'b1);
    idle(5);
    chk("after_break_xfers", xlog.size() - n0, 1);
    if (xlog.size() > n0) chk("after_break_byte", int'(xlog[n0]), 8'h7E);

    // Short low glitch.
    n0 = xlog.size();
    @(posedge clk); #1;
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    chk("glitch_busy_high", int'(busy), 1);
    idle(30);
    chk("glitch_busy_low", int'(busy), 0);
    chk("glitch_no_valid", xlog.size() - n0, 0);

    // Reset in the middle of a data phase.
    n0 = xlog.size();
    begin
      ev_t e;
      logic [7:0] b;
      b = 8'h99;
      @(posedge clk); #1;
      t0r    = cyc + 1;
      e.t    = t0r + 2 + H + 9 * C;
      e.b    = b;
      e.stop = 1'b1;
      evq.push_back(e);
      rxd = 1'b0;
      for (int i = 0; i < 4; i++) begin
        repeat (C) @(posedge clk); #1;
        rxd = b[i];
      end
      repeat (C) @(posedge clk); #1;
    end
    chk("rst_busy_before", int'(busy), 1);
    rst = 1'b1;
    rxd = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("rst_mid_valid", int'(valid), 0);
    chk("rst_mid_data", int'(data), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_flags", int'(frame_err) + int'(overrun), 0);
    idle(10);
    send_frame(8'h42, 1'b1);
    idle(5);
    chk("after_rst_xfers", xlog.size() - n0, 1);
    if (xlog.size() > n0) chk("after_rst_byte", int'(xlog[n0]), 8'h42);

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
